// File: rtl/rmap_command_encoder.sv
// rtl/rmap_command_encoder.sv - RMAP command packet encoder feeding a SpaceWire TX FIFO.
// Optional abort/EEP support is compiled in with RMAP_ENC_ABORT_EN.
module rmap_command_encoder #(
  parameter int BUS_WIDTH = 32,
  parameter int MAX_WORDS = 256,
  localparam int WW = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 startIn,
  input  logic [1:0]           cmdType,
  input  logic                 cmdIncrement,
  input  logic                 cmdVerify,
  input  logic                 cmdReply,
  input  logic [WW-1:0]        cmdWords,
  input  logic [1:0]           replyAddrLen,
  input  logic [95:0]          replyAddr,
  input  logic [7:0]           key,
  input  logic [7:0]           targLogAddr,
  input  logic [7:0]           initLogAddr,
  input  logic [7:0]           extAddr,
  input  logic [15:0]          transID,
  input  logic [31:0]          addr,
  input  logic [BUS_WIDTH-1:0] dataIn,
  input  logic                 dataValid,
  output logic                 dataReady,
  output logic                 txWriteEnable,
  output logic [8:0]           txDataIn,
  input  logic                 txFull,
  input  logic                 abortIn,
  output logic                 busy,
  output logic                 donePulse,
  output logic                 cmdError
);
  localparam int BYTES = BUS_WIDTH / 8;
  localparam int BCW = $clog2(BYTES + 1);

  typedef enum logic [2:0] {IDLE, HDR, HCRC, DATA, DCRC, EOP, FIN} stateT;
  stateT state;

  logic [1:0]           typeR, rlR;
  logic                 incR, verR, repR, eep, pend;
  logic [WW-1:0]        wordsR, wordsLeft;
  logic [95:0]          raR;
  logic [7:0]           keyR, targR, initR, extR, crc, hdrByte, instr;
  logic [15:0]          tidR;
  logic [31:0]          addrR;
  logic [4:0]           hdrIdx, rBytes, rel, hdrLast, replyIdx;
  logic [3:0]           sh;
  logic [23:0]          dataLen;
  logic [BCW-1:0]       bytesLeft;
  logic [BUS_WIDTH-1:0] wordBuf;
  logic                 slot, accept, abortHit, startErr;

  // RMAP CRC-8, reflected polynomial 0x07, one byte per call
  function automatic logic [7:0] crcByte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 8'hE0) : (x >> 1);
    return x;
  endfunction

  // A new byte may be loaded whenever the holding register is empty or is leaving this edge
  assign slot          = !pend || !txFull;
  assign txWriteEnable = pend && !txFull;
  assign dataReady     = (state == DATA) && (bytesLeft == '0) && (wordsLeft != '0);
  assign accept        = dataValid && dataReady;
  assign startErr      = (cmdType == 2'd3) || (cmdType == 2'd2 && cmdWords != WW'(2)) ||
                         (cmdWords > WW'(MAX_WORDS));

`ifdef RMAP_ENC_ABORT_EN
  assign abortHit = abortIn && (state == HDR || state == HCRC || state == DATA || state == DCRC);
`else
  logic unusedAbort;
  assign unusedAbort = abortIn;
  assign abortHit    = 1'b0;
`endif

  assign rBytes   = {1'b0, rlR, 2'b00};
  assign hdrLast  = 5'd14 + rBytes;
  assign rel      = hdrIdx - rBytes;
  assign replyIdx = hdrIdx - 5'd4;
  assign sh       = 4'(rBytes - 5'd1 - replyIdx);
  assign dataLen  = 24'(wordsR) * 24'(BYTES);

  always_comb begin
    case (typeR)
      2'd0:    instr = {2'b01, 1'b0, 1'b0, 1'b1, incR, rlR};
      2'd1:    instr = {2'b01, 1'b1, verR, repR, incR, rlR};
      default: instr = {2'b01, 4'b0111, rlR};
    endcase
  end

  always_comb begin
    hdrByte = 8'h00;
    if (hdrIdx == 5'd1) hdrByte = 8'h01;
    else if (hdrIdx == 5'd2) hdrByte = instr;
    else if (hdrIdx == 5'd3) hdrByte = keyR;
    else if (hdrIdx < 5'd4 + rBytes) hdrByte = raR[{sh, 3'b000} +: 8];
    else begin
      case (rel)
        5'd4:    hdrByte = initR;
        5'd5:    hdrByte = tidR[15:8];
        5'd6:    hdrByte = tidR[7:0];
        5'd7:    hdrByte = extR;
        5'd8:    hdrByte = addrR[31:24];
        5'd9:    hdrByte = addrR[23:16];
        5'd10:   hdrByte = addrR[15:8];
        5'd11:   hdrByte = addrR[7:0];
        5'd12:   hdrByte = dataLen[23:16];
        5'd13:   hdrByte = dataLen[15:8];
        5'd14:   hdrByte = dataLen[7:0];
        default: hdrByte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; typeR <= '0; rlR <= '0; incR <= 1'b0; verR <= 1'b0; repR <= 1'b0;
      eep <= 1'b0; pend <= 1'b0; wordsR <= '0; wordsLeft <= '0; raR <= '0;
      keyR <= '0; targR <= '0; initR <= '0; extR <= '0; crc <= 8'h00; tidR <= '0;
      addrR <= '0; hdrIdx <= '0; bytesLeft <= '0; wordBuf <= '0; txDataIn <= '0;
      busy <= 1'b0; donePulse <= 1'b0; cmdError <= 1'b0;
    end else begin
      donePulse <= 1'b0;
      cmdError  <= 1'b0;
      if (abortHit) begin
        if (slot) pend <= 1'b0;
        eep   <= 1'b1;
        state <= EOP;
      end else begin
        case (state)
          IDLE: if (startIn) begin
            if (startErr) cmdError <= 1'b1;
            else begin
              typeR <= cmdType; incR <= cmdIncrement; verR <= cmdVerify; repR <= cmdReply;
              wordsR <= cmdWords; rlR <= replyAddrLen; raR <= replyAddr; keyR <= key;
              targR <= targLogAddr; initR <= initLogAddr; extR <= extAddr;
              tidR <= transID; addrR <= addr; eep <= 1'b0;
              // First byte goes straight into the holding register so it leaves next cycle
              txDataIn <= {1'b0, targLogAddr};
              pend     <= 1'b1;
              crc      <= crcByte(8'h00, targLogAddr);
              hdrIdx   <= 5'd1;
              busy     <= 1'b1;
              state    <= HDR;
            end
          end
          HDR: if (slot) begin
            txDataIn <= {1'b0, hdrByte};
            pend     <= 1'b1;
            crc      <= crcByte(crc, hdrByte);
            hdrIdx   <= hdrIdx + 5'd1;
            if (hdrIdx == hdrLast) state <= HCRC;
          end
          HCRC: if (slot) begin
            txDataIn  <= {1'b0, crc};
            pend      <= 1'b1;
            crc       <= 8'h00;
            wordsLeft <= wordsR;
            bytesLeft <= '0;
            if (typeR == 2'd0) state <= EOP;
            else if (wordsR == '0) state <= DCRC;
            else state <= DATA;
          end
          DATA: begin
            if (slot) begin
              if (bytesLeft != '0) begin
                txDataIn  <= {1'b0, wordBuf[BUS_WIDTH-1 -: 8]};
                pend      <= 1'b1;
                crc       <= crcByte(crc, wordBuf[BUS_WIDTH-1 -: 8]);
                wordBuf   <= wordBuf << 8;
                bytesLeft <= bytesLeft - BCW'(1);
                if (bytesLeft == BCW'(1) && wordsLeft == '0) state <= DCRC;
              end else if (accept) begin
                // Prefetched word: its MS byte bypasses the buffer to avoid a bubble
                txDataIn  <= {1'b0, dataIn[BUS_WIDTH-1 -: 8]};
                pend      <= 1'b1;
                crc       <= crcByte(crc, dataIn[BUS_WIDTH-1 -: 8]);
                wordBuf   <= dataIn << 8;
                bytesLeft <= BCW'(BYTES - 1);
                wordsLeft <= wordsLeft - WW'(1);
                if (BYTES == 1 && wordsLeft == WW'(1)) state <= DCRC;
              end else pend <= 1'b0;
            end else if (accept) begin
              wordBuf   <= dataIn;
              bytesLeft <= BCW'(BYTES);
              wordsLeft <= wordsLeft - WW'(1);
            end
          end
          DCRC: if (slot) begin
            txDataIn <= {1'b0, crc};
            pend     <= 1'b1;
            state    <= EOP;
          end
          EOP: if (slot) begin
            txDataIn <= eep ? 9'h101 : 9'h100;
            pend     <= 1'b1;
            state    <= FIN;
          end
          FIN: if (slot) begin
            pend      <= 1'b0;
            busy      <= 1'b0;
            donePulse <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/rmap_command_encoder.md
# rmap_command_encoder

Builds complete RMAP command packets (read, write, read-modify-write) from a parameter set and a word-wide data stream, then emits them byte-serially into the SpaceWire TX FIFO interface (9-bit, flag in bit 8).
- It is the initiator-side counterpart of the RMAP target and adds two features in RTL: multi-word payloads and reply-address fields of 0/4/8/12 bytes.
- It sits between a host command register file and the SpaceWire link TX FIFO.

## Interface
Parameters:
- BUS_WIDTH, 32: data word width in bits; 8, 16 or 32.
- MAX_WORDS, 256: maximum payload words per command.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- startIn  in  1  command request; sampled only while busy=0.
- cmdType  in  2  0=read, 1=write, 2=RMW, 3=illegal.
- cmdIncrement, cmdVerify, cmdReply  in  1 each  instruction flag bits.
- cmdWords  in  $clog2(MAX_WORDS+1)  payload word count.
- replyAddrLen  in  2  number of reply-address words: 0..3, giving 0/4/8/12 bytes.
- replyAddr  in  96  reply address; the bytes sent are taken MS byte first from the low replyAddrLen*32 bits.
- key, targLogAddr, initLogAddr, extAddr  in  8 each  header fields.
- transID  in  16  transaction ID.
- addr  in  32  memory address.
- dataIn  in  BUS_WIDTH  payload word.
- dataValid  in  1  dataIn is valid.
- dataReady  out  1  encoder accepts dataIn on this cycle.
- txWriteEnable  out  1  FIFO write strobe.
- txDataIn  out  9  {flag, byte}.
- txFull  in  1  FIFO full.
- abortIn  in  1  terminate the current packet (see Configuration).
- busy  out  1  a command is in progress.
- donePulse  out  1  packet fully written.
- cmdError  out  1  the start request was rejected.

## Operation
- States: IDLE → HDR → HCRC → (DATA → DCRC) → EOP → IDLE.
- IDLE: when startIn=1, all cmd*/header inputs are registered.
  - cmdType=3, or RMW with cmdWords≠2, or cmdWords>MAX_WORDS: pulse cmdError for 1 cycle and stay in IDLE.
- Instruction byte: {2'b01, W, V, R, I, replyAddrLen}.
  - Read: W=0, V=0, R=1, I=cmdIncrement.
  - Write: W=1, V=cmdVerify, R=cmdReply, I=cmdIncrement.
  - RMW: fixed 0111.
- HDR byte order:
  - targLogAddr, 0x01, instruction, key;
  - reply-address bytes;
  - initLogAddr, transID[15:8], transID[7:0], extAddr;
  - addr MS→LS;
  - dataLen[23:0] MS→LS, where dataLen = cmdWords*BUS_WIDTH/8.
- HCRC: emit the CRC over all HDR bytes.
  - CRC is RMAP CRC-8 (ECSS-E-ST-50-52C), init 0x00, LSB-first reflected; single-byte CRC of 0x01 = 0x91.
  - Computed incrementally, one byte per cycle.
- DATA (write/RMW only):
  - Fetch a word on dataValid&dataReady.
  - Emit its BUS_WIDTH/8 bytes MS first.
  - dataReady=1 only when in DATA with the byte buffer empty.
- RMW stream order is data word then mask word.
- DCRC: CRC over the payload bytes. Write with cmdWords=0 skips DATA and emits DCRC=0x00.
- Read skips DATA and DCRC.
- EOP: emit {1'b1, 8'h00}, then pulse donePulse and return to IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; CRC 0x00.
- Reset mid-packet aborts immediately; no EOP or EEP is emitted.
- txWriteEnable = byte pending & !txFull, combinational on txFull. A byte counts as sent on the edge where txWriteEnable=1.
- Throughput: 1 byte/cycle with txFull=0.
- The first header byte can be written in the cycle after startIn is sampled.
- The payload prefetches the next word during the last byte of the current one, so no bubble occurs when dataValid stays high.
- busy rises the cycle after an accepted start. busy falls and donePulse rises (1 cycle) the cycle after EOP is written.
- A new startIn is sampled in the same cycle that donePulse is high.
- txFull stalls hold txDataIn stable. dataValid=0 in DATA stalls emission without error.
- startIn while busy=1 is ignored (no cmdError).

## Configuration
- Macro: RMAP_ENC_ABORT_EN.
- Defined:
  - abortIn=1 in HDR/HCRC/DATA/DCRC moves to EOP, which emits EEP {1'b1, 8'h01} instead of EOP.
  - donePulse still pulses; cmdError stays 0.
  - abortIn in IDLE or EOP is ignored.
- Undefined: the port exists but is ignored; no abort logic is synthesised.

## Test plan
- Write single word:
  - Stimulus: addr 0x04, data 0x89ABCDEF, key 0x20, targLogAddr 0xFE, initLogAddr 0x99, transID 0x1234, V=R=1, I=0.
  - Response: 21 bytes + EOP; byte 2=0x78; dataLen 00 00 04; both CRCs match the software table model.
- Read, incrementing, 3 words, addr 0x08:
  - Response: instruction 0x4C; dataLen 00 00 0C; 16 bytes + EOP; dataReady never asserts.
- RMW:
  - Stimulus: data 0xAAFF99FF then mask 0xFF00FF00.
  - Response: instruction 0x5C; dataLen 00 00 08; payload AA FF 99 FF FF 00 FF 00 + CRC.
  - RMW with cmdWords=3 → cmdError pulse, no FIFO writes.
- Reply address and stalls:
  - Stimulus: replyAddrLen=2, replyAddr=0x0102_0304_0506_0708; txFull randomized at 80% high; dataValid toggling.
  - Response: instruction LSBs=2'b10; 8 reply bytes 01..08 after key; byte stream identical to the unstalled run.
- Abort (RMAP_ENC_ABORT_EN defined):
  - Stimulus: abortIn pulsed during the 2nd payload word of a 4-word write.
  - Response: EEP {1,0x01} follows the last written byte; donePulse=1; next command encodes correctly.
- Reset mid-header:
  - Stimulus: rst asserted at byte 5.
  - Response: txWriteEnable=0, busy=0 immediately; the next command starts with a fresh CRC.
